// File: rtl/aes_mode_ctrl.sv
// AES-128 block-mode controller: sequences ECB / CBC / CTR messages through an
// external AES core, handling chaining / counter state and the in/out handshakes.
module aes_mode_ctrl #(
    parameter int BLK_W = 16,
    parameter int CTR_W = 32
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_fStart,
    input  logic               i_fEnc,
    input  logic [1:0]         i_Mode,
    input  logic [127:0]       i_Key,
    input  logic [127:0]       i_IV,
    input  logic [BLK_W-1:0]   i_NumBlk,
    input  logic               i_fValid,
    input  logic [127:0]       i_Text,
    output logic               o_fReady,
    output logic               o_fValid,
    output logic [127:0]       o_Data,
    input  logic               i_fReady,
    output logic               o_fBusy,
    output logic               o_fDone,
    output logic               o_fErr,
    output logic               o_Core_fStart,
    output logic               o_Core_fEnc,
    output logic [127:0]       o_Core_Key,
    output logic [127:0]       o_Core_Text,
    input  logic [127:0]       i_Core_Data,
    input  logic               i_Core_fDone
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_IN    = 3'd1;
    localparam logic [2:0] S_CORE_START = 3'd2;
    localparam logic [2:0] S_CORE_WAIT  = 3'd3;
    localparam logic [2:0] S_OUTPUT     = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    localparam logic [1:0] M_ECB = 2'b00;
    localparam logic [1:0] M_CBC = 2'b01;
    localparam logic [1:0] M_CTR = 2'b10;
    localparam logic [1:0] M_RSV = 2'b11;

    localparam logic [BLK_W-1:0] BLK_ONE = BLK_W'(1);
    localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

    logic [2:0]       r_State;
    logic             r_fEnc;
    logic [1:0]       r_Mode;
    logic [127:0]     r_Key;
    logic [127:0]     r_Chain;      // CBC chaining value or CTR counter block
    logic [127:0]     r_Text;       // accepted input block, needed after the core returns
    logic [BLK_W-1:0] r_Remain;
    logic [127:0]     r_CoreText;
    logic             r_CoreEnc;
    logic [127:0]     r_Data;
    logic             r_fErr;

    logic [127:0]     w_CoreText;
    logic             w_CoreEnc;
    logic [127:0]     w_Result;
    logic [127:0]     w_NextChain;
    logic [127:0]     w_CtrNext;

    // Counter increment wraps within the low field; the nonce part never changes.
    assign w_CtrNext = {r_Chain[127:CTR_W], r_Chain[CTR_W-1:0] + CTR_ONE};

    // Core operand selection for the block being accepted in WAIT_IN.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch inferred.
        w_CoreText = i_Text;
        w_CoreEnc  = r_fEnc;
        case (r_Mode)
            M_CBC: begin
                if (r_fEnc) w_CoreText = i_Text ^ r_Chain;
                else        w_CoreEnc  = 1'b0;
            end
            M_CTR: begin
                w_CoreText = r_Chain;
                w_CoreEnc  = 1'b1;
            end
            default: ;
        endcase
    end

    // Output block and next chain/counter value from the core result.
    always_comb begin
        w_Result    = i_Core_Data;
        w_NextChain = r_Chain;
        case (r_Mode)
            M_CBC: begin
                if (r_fEnc) begin
                    w_NextChain = i_Core_Data;
                end else begin
                    w_Result    = i_Core_Data ^ r_Chain;
                    w_NextChain = r_Text;
                end
            end
            M_CTR: begin
                w_Result    = i_Core_Data ^ r_Text;
                w_NextChain = w_CtrNext;
            end
            default: ;
        endcase
    end

    // Message FSM plus all datapath registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_State    <= S_IDLE;
            r_fEnc     <= 1'b1;
            r_Mode     <= M_ECB;
            r_Key      <= '0;
            r_Chain    <= '0;
            r_Text     <= '0;
            r_Remain   <= '0;
            r_CoreText <= '0;
            r_CoreEnc  <= 1'b1;
            r_Data     <= '0;
            r_fErr     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            r_fErr <= 1'b0;
            case (r_State)
                S_IDLE: begin
                    if (i_fStart) begin
                        if (i_Mode == M_RSV) begin
                            r_fErr <= 1'b1;
                        end else if (i_NumBlk == '0) begin
                            r_State <= S_DONE;
                        end else begin
                            r_fEnc   <= i_fEnc;
                            r_Mode   <= i_Mode;
                            r_Key    <= i_Key;
                            r_Chain  <= i_IV;
                            r_Remain <= i_NumBlk;
                            r_State  <= S_WAIT_IN;
                        end
                    end
                end
                S_WAIT_IN: begin
                    if (i_fValid) begin
                        r_Text     <= i_Text;
                        r_CoreText <= w_CoreText;
                        r_CoreEnc  <= w_CoreEnc;
                        r_State    <= S_CORE_START;
                    end
                end
                S_CORE_START: r_State <= S_CORE_WAIT;
                S_CORE_WAIT: begin
                    if (i_Core_fDone) begin
                        r_Data  <= w_Result;
                        r_Chain <= w_NextChain;
                        r_State <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (i_fReady) begin
                        r_Remain <= r_Remain - BLK_ONE;
                        r_State  <= (r_Remain == BLK_ONE) ? S_DONE : S_WAIT_IN;
                    end
                end
                S_DONE:  r_State <= S_IDLE;
                default: r_State <= S_IDLE;
            endcase
        end
    end

    assign o_fReady      = (r_State == S_WAIT_IN);
    assign o_fValid      = (r_State == S_OUTPUT);
    assign o_fBusy       = (r_State != S_IDLE);
    assign o_fDone       = (r_State == S_DONE);
    assign o_fErr        = r_fErr;
    assign o_Core_fStart = (r_State == S_CORE_START);
    assign o_Core_fEnc   = r_CoreEnc;
    assign o_Core_Key    = r_Key;
    assign o_Core_Text   = r_CoreText;
    assign o_Data        = r_Data;

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Scoreboard bench for aes_mode_ctrl: stimulus pushes expected core requests and
// output blocks; a core model and an output monitor pop and compare them.
module tb_aes_mode_ctrl;

    localparam logic [127:0] KEY   = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] P_VEC = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] C_VEC = 128'h29C3505F571420F6402299B31A02D73A;

    logic           i_Clk = 1'b0;
    logic           i_Rst;
    logic           i_fStart;
    logic           i_fEnc;
    logic [1:0]     i_Mode;
    logic [127:0]   i_Key;
    logic [127:0]   i_IV;
    logic [15:0]    i_NumBlk;
    logic           i_fValid;
    logic [127:0]   i_Text;
    logic           o_fReady;
    logic           o_fValid;
    logic [127:0]   o_Data;
    logic           i_fReady;
    logic           o_fBusy;
    logic           o_fDone;
    logic           o_fErr;
    logic           o_Core_fStart;
    logic           o_Core_fEnc;
    logic [127:0]   o_Core_Key;
    logic [127:0]   o_Core_Text;
    logic [127:0]   i_Core_Data;
    logic           i_Core_fDone;

    aes_mode_ctrl #(.BLK_W(16), .CTR_W(32)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_fStart(i_fStart), .i_fEnc(i_fEnc),
        .i_Mode(i_Mode), .i_Key(i_Key), .i_IV(i_IV), .i_NumBlk(i_NumBlk),
        .i_fValid(i_fValid), .i_Text(i_Text), .o_fReady(o_fReady),
        .o_fValid(o_fValid), .o_Data(o_Data), .i_fReady(i_fReady),
        .o_fBusy(o_fBusy), .o_fDone(o_fDone), .o_fErr(o_fErr),
        .o_Core_fStart(o_Core_fStart), .o_Core_fEnc(o_Core_fEnc),
        .o_Core_Key(o_Core_Key), .o_Core_Text(o_Core_Text),
        .i_Core_Data(i_Core_Data), .i_Core_fDone(i_Core_fDone)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [127:0] text;
        logic         enc;
        logic [127:0] key;
    } core_exp_t;

    core_exp_t    core_q[$];
    logic [127:0] out_q[$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int start_cnt = 0;
    bit core_silent = 1'b0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stand-in AES core: known-answer pair, otherwise a self-inverse XOR with the key.
    function automatic logic [127:0] fake_core(input logic [127:0] t, input logic e);
        if (e && t == P_VEC) return C_VEC;
        if (!e && t == C_VEC) return P_VEC;
        return t ^ KEY;
    endfunction

    // Core model: checks each request against the scoreboard and answers after 3 cycles.
    initial begin
        core_exp_t    e;
        logic [127:0] d;
        i_Core_fDone = 1'b0;
        i_Core_Data  = '0;
        forever begin
            @(negedge i_Clk);
            if (o_Core_fStart === 1'b1) begin
                start_cnt++;
                if (core_q.size() == 0) begin
                    check("unexpected_core_start", o_Core_fStart, 0);
                end else begin
                    e = core_q.pop_front();
                    check("core_text", o_Core_Text, e.text);
                    check("core_enc", o_Core_fEnc, e.enc);
                    check("core_key", o_Core_Key, e.key);
                end
                d = fake_core(o_Core_Text, o_Core_fEnc);
                if (!core_silent) begin
                    repeat (3) @(posedge i_Clk);
                    #1 i_Core_Data = d;
                    i_Core_fDone = 1'b1;
                    @(posedge i_Clk);
                    #1 i_Core_fDone = 1'b0;
                    check("valid_latency", o_fValid, 1);
                end
            end
        end
    end

    // Output monitor: compares accepted blocks and tracks done/err pulses.
    initial begin
        logic [127:0] exp;
        forever begin
            @(negedge i_Clk);
            if (o_fValid === 1'b1 && i_fReady === 1'b1) begin
                if (out_q.size() == 0) begin
                    check("unexpected_output", o_fValid, 0);
                end else begin
                    exp = out_q.pop_front();
                    check("out_data", o_Data, exp);
                end
            end
            if (o_fDone === 1'b1) begin
                done_cnt++;
                check("done_pulse_width", prev_done, 0);
            end
            prev_done = o_fDone;
            if (o_fErr === 1'b1) err_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic start_msg(input logic enc, input logic [1:0] mode, input logic [127:0] iv,
                             input logic [15:0] nblk);
        @(posedge i_Clk);
        #1 i_fStart = 1'b1;
        i_fEnc   = enc;
        i_Mode   = mode;
        i_Key    = KEY;
        i_IV     = iv;
        i_NumBlk = nblk;
        @(posedge i_Clk);
        #1 i_fStart = 1'b0;
    endtask

    task automatic push_exp(input logic [127:0] ctext, input logic cenc, input logic [127:0] dout);
        core_exp_t e;
        e.text = ctext;
        e.enc  = cenc;
        e.key  = KEY;
        core_q.push_back(e);
        out_q.push_back(dout);
    endtask

    task automatic send_block(input logic [127:0] txt);
        bit seen = 1'b0;
        i_fValid = 1'b1;
        i_Text   = txt;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_Clk);
            if (o_fReady === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("ready_timeout", o_fReady, 1);
        @(posedge i_Clk);
        #1 i_fValid = 1'b0;
        if (seen) check("core_start_latency", o_Core_fStart, 1);
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 200; i++) begin
            @(negedge i_Clk);
            if (done_cnt >= n) break;
        end
        check("done_count", done_cnt, n);
    endtask

    task automatic check_reset_vals();
        check("rst_busy", o_fBusy, 0);
        check("rst_ready", o_fReady, 0);
        check("rst_valid", o_fValid, 0);
        check("rst_done", o_fDone, 0);
        check("rst_err", o_fErr, 0);
        check("rst_core_start", o_Core_fStart, 0);
        check("rst_data", o_Data, 0);
        check("rst_core_text", o_Core_Text, 0);
        check("rst_core_key", o_Core_Key, 0);
        check("rst_core_enc", o_Core_fEnc, 1);
    endtask

    initial begin
        logic [127:0] c2;
        logic [127:0] ctr_iv;
        logic [127:0] ctr_iv2;
        logic [127:0] t1;
        logic [127:0] t2;
        int s0;
        int e0;
        bit seen;

        c2      = P_VEC ^ C_VEC ^ KEY;
        ctr_iv  = 128'h0123456789ABCDEF02468ACEFFFFFFFF;
        ctr_iv2 = 128'h0123456789ABCDEF02468ACE00000000;
        t1      = 128'h00112233445566778899AABBCCDDEEFF;
        t2      = 128'hA5A5A5A5A5A5A5A55A5A5A5A5A5A5A5A;

        i_Rst = 1'b1;
        i_fStart = 1'b0; i_fEnc = 1'b1; i_Mode = 2'b00; i_Key = '0; i_IV = '0;
        i_NumBlk = '0; i_fValid = 1'b0; i_Text = '0; i_fReady = 1'b1;
        repeat (3) @(posedge i_Clk);
        #1 check_reset_vals();
        i_Rst = 1'b0;

        // ECB encrypt then decrypt of the known-answer vector
        start_msg(1'b1, 2'b00, '0, 16'd1);
        push_exp(P_VEC, 1'b1, C_VEC);
        send_block(P_VEC);
        wait_done(1);
        start_msg(1'b0, 2'b00, '0, 16'd1);
        push_exp(C_VEC, 1'b0, P_VEC);
        send_block(C_VEC);
        wait_done(2);

        // CBC encrypt two identical blocks, then decrypt the result
        start_msg(1'b1, 2'b01, '0, 16'd2);
        push_exp(P_VEC, 1'b1, C_VEC);
        push_exp(P_VEC ^ C_VEC, 1'b1, c2);
        send_block(P_VEC);
        send_block(P_VEC);
        wait_done(3);
        start_msg(1'b0, 2'b01, '0, 16'd2);
        push_exp(C_VEC, 1'b0, P_VEC);
        push_exp(c2, 1'b0, P_VEC);
        send_block(C_VEC);
        send_block(c2);
        wait_done(4);

        // CTR with fEnc=0: core always encrypts, low counter field wraps
        start_msg(1'b0, 2'b10, ctr_iv, 16'd2);
        push_exp(ctr_iv, 1'b1, ctr_iv ^ KEY ^ t1);
        push_exp(ctr_iv2, 1'b1, ctr_iv2 ^ KEY ^ t2);
        send_block(t1);
        send_block(t2);
        wait_done(5);

        // Output back-pressure for 5 cycles
        i_fReady = 1'b0;
        start_msg(1'b1, 2'b00, '0, 16'd1);
        push_exp(P_VEC, 1'b1, C_VEC);
        send_block(P_VEC);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_Clk);
            if (o_fValid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("stall_valid_seen", o_fValid, 1);
        s0 = start_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_Clk);
            check("stall_valid", o_fValid, 1);
            check("stall_data", o_Data, C_VEC);
            check("stall_ready", o_fReady, 0);
            check("stall_no_core_start", start_cnt, s0);
        end
        @(posedge i_Clk);
        #1 i_fReady = 1'b1;
        wait_done(6);

        // Zero-length message: done without core activity
        s0 = start_cnt;
        start_msg(1'b1, 2'b00, '0, 16'd0);
        wait_done(7);
        check("zero_blk_no_core", start_cnt, s0);

        // Reserved mode: error pulse, never busy
        e0 = err_cnt;
        start_msg(1'b1, 2'b11, '0, 16'd1);
        check("rsv_err_pulse", o_fErr, 1);
        check("rsv_busy", o_fBusy, 0);
        @(posedge i_Clk);
        #1 check("rsv_err_clear", o_fErr, 0);
        check("rsv_busy_after", o_fBusy, 0);

        // Start pulse while waiting on the core is ignored
        start_msg(1'b1, 2'b00, '0, 16'd1);
        push_exp(P_VEC, 1'b1, C_VEC);
        send_block(P_VEC);
        @(posedge i_Clk);
        #1 i_fStart = 1'b1;
        i_Mode   = 2'b11;
        i_NumBlk = 16'd3;
        @(posedge i_Clk);
        #1 i_fStart = 1'b0;
        wait_done(8);
        @(posedge i_Clk);
        #1 check("ignored_start_idle", o_fBusy, 0);
        check("err_count", err_cnt, e0 + 1);

        // Asynchronous reset while in CORE_WAIT, then a fresh ECB message
        core_silent = 1'b1;
        start_msg(1'b1, 2'b00, '0, 16'd1);
        push_exp(P_VEC, 1'b1, C_VEC);
        send_block(P_VEC);
        repeat (2) @(posedge i_Clk);
        #1 check("pre_reset_busy", o_fBusy, 1);
        #1 i_Rst = 1'b1;
        #1 check_reset_vals();
        @(posedge i_Clk);
        #1 i_Rst = 1'b0;
        core_silent = 1'b0;
        out_q.delete();
        core_q.delete();
        start_msg(1'b1, 2'b00, '0, 16'd1);
        push_exp(P_VEC, 1'b1, C_VEC);
        send_block(P_VEC);
        wait_done(9);

        repeat (5) @(posedge i_Clk);
        check("out_queue_empty", out_q.size(), 0);
        check("core_queue_empty", core_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
